// File: rtl/complex_result_collector.sv
// complex_result_collector
// Captures the non-stallable result stream of the complex ALU. Consecutive
// results are optionally summed into groups with per-component saturation.
// Finished sums are queued in a fall-through FIFO that drains over
// valid/ready. An in-flight counter produces a credit (issue_ok), so that no
// operation is launched unless its result is guaranteed a FIFO slot.
//
// Accumulator FSM
//   state  | meaning
//   S_IDLE | no group open; the next result starts a group (acc_len sampled)
//   S_ACC  | group open; cnt_q results already summed into acc_*_q
module complex_result_collector #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int DEPTH      = 8,
   parameter int LATENCY    = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                acc_len,
   input  logic                      issue,
   output logic                      issue_ok,
   input  logic                      alu_valid,
   input  logic [2*DATA_WIDTH-1:0]   alu_result,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*ACC_WIDTH-1:0]    out_data,
   input  logic                      flush,
   input  logic                      clear_err,
   output logic                      overflow,
   output logic                      underflow,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int OW = PW + 1;
   // Extra headroom lets issues beyond the credit be counted rather than lost.
   localparam int IW = $clog2(DEPTH + LATENCY + 1) + 1;
   localparam int LW = IW + 1;
   localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);
   localparam logic [IW-1:0] INF_MAX  = {IW{1'b1}};
   localparam logic [LW-1:0] LOAD_LIM = LW'(DEPTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACC  = 1'b1
   } state_t;

   // Signed add of a sign-extended result onto an accumulator, clamped to the
   // ACC_WIDTH range. One guard bit is enough because both operands fit.
   function automatic logic [ACC_WIDTH-1:0] sat_add(
      input logic [ACC_WIDTH-1:0]  a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [ACC_WIDTH:0] s;
      s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH + 1 - DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
      if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
         sat_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else
         sat_add = s[ACC_WIDTH-1:0];
   endfunction

   state_t                 state_q;
   logic [7:0]             len_q;
   logic [7:0]             cnt_q;
   logic [ACC_WIDTH-1:0]   acc_re_q;
   logic [ACC_WIDTH-1:0]   acc_im_q;

   logic [7:0]             len_eff;
   logic [ACC_WIDTH-1:0]   base_re;
   logic [ACC_WIDTH-1:0]   base_im;
   logic [ACC_WIDTH-1:0]   sum_re;
   logic [ACC_WIDTH-1:0]   sum_im;
   logic                   push;
   logic [2*ACC_WIDTH-1:0] push_data;

   logic [2*ACC_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]          wr_ptr_q;
   logic [PW-1:0]          rd_ptr_q;
   logic [OW-1:0]          count_q;
   logic [OW-1:0]          count_d;
   logic                   full;
   logic                   pop;
   logic                   wr_en;
   logic                   drop;

   logic [IW-1:0]          inflight_q;
   logic [IW-1:0]          inflight_d;
   logic [LW-1:0]          load;

   logic                   overflow_q;
   logic                   underflow_q;

   // Group sum datapath and completion detect; the first result of a group
   // is added onto zero so the same saturating adder serves both states.
   always_comb begin
      len_eff   = (acc_len == 8'd0) ? 8'd1 : acc_len;
      base_re   = (state_q == S_ACC) ? acc_re_q : '0;
      base_im   = (state_q == S_ACC) ? acc_im_q : '0;
      sum_re    = sat_add(base_re, alu_result[2*DATA_WIDTH-1:DATA_WIDTH]);
      sum_im    = sat_add(base_im, alu_result[DATA_WIDTH-1:0]);
      push_data = {sum_re, sum_im};
      push      = 1'b0;
      if (alu_valid && !flush) begin
         if (state_q == S_IDLE)
            push = (len_eff == 8'd1);
         else
            push = ((cnt_q + 8'd1) == len_q);
      end
   end

   // Accumulator FSM: opens, extends and closes groups; flush abandons a group.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= 8'd1;
         cnt_q    <= 8'd0;
         acc_re_q <= '0;
         acc_im_q <= '0;
      end else if (flush) begin
         state_q <= S_IDLE;
      end else if (alu_valid) begin
         acc_re_q <= sum_re;
         acc_im_q <= sum_im;
         if (state_q == S_IDLE) begin
            len_q   <= len_eff;
            cnt_q   <= 8'd1;
            state_q <= (len_eff == 8'd1) ? S_IDLE : S_ACC;
         end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= push ? S_IDLE : S_ACC;
         end
      end
   end

   // FIFO control: a pop on a full FIFO makes room for a same-cycle push.
   always_comb begin
      full    = (count_q == FULL_CNT);
      pop     = out_valid && out_ready && !flush;
      wr_en   = push && (!full || pop);
      drop    = push && full && !pop;
      count_d = count_q;
      if (flush)
         count_d = '0;
      else if (wr_en && !pop)
         count_d = count_q + OW'(1);
      else if (!wr_en && pop)
         count_d = count_q - OW'(1);
   end

   // FIFO pointers and entry count; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (wr_en)
               wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
               rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // FIFO storage; contents are only observable through a valid head.
   always_ff @(posedge clk) begin
      if (wr_en && !flush)
         mem_q[wr_ptr_q] <= push_data;
   end

   // In-flight bookkeeping; flush does not cancel operations already launched.
   always_comb begin
      inflight_d = inflight_q;
      if (issue && !alu_valid) begin
         if (inflight_q != INF_MAX)
            inflight_d = inflight_q + IW'(1);
      end else if (!issue && alu_valid) begin
         if (inflight_q != '0)
            inflight_d = inflight_q - IW'(1);
      end
   end

   // In-flight counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         inflight_q <= '0;
      else
         inflight_q <= inflight_d;
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= drop || (overflow_q && !clear_err);
         underflow_q <= (alu_valid && (inflight_q == '0)) || (underflow_q && !clear_err);
      end
   end

   // Every in-flight result is treated as a future FIFO entry.
   always_comb begin
      load     = LW'(count_q) + LW'(inflight_q);
      issue_ok = (load < LOAD_LIM);
   end

   assign out_valid = (count_q != '0);
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
   assign occupancy = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: doc/complex_result_collector.md
# complex_result_collector

Downstream stage of the EdgeNPU complex ALU. It captures the fixed-latency result stream from the ALU, which cannot be stalled. It optionally accumulates groups of consecutive complex results and buffers the finished sums in a FIFO that drains over a valid/ready interface. It also returns a credit signal so the upstream issuer never launches an operation whose result could not be stored.

## Interface
- DATA_WIDTH, 16, width of each real/imag component of an ALU result
- ACC_WIDTH, 24, width of each accumulated component (≥ DATA_WIDTH)
- DEPTH, 8, FIFO entries (power of 2, ≥ 2)
- LATENCY, 8, ALU issue-to-result latency in cycles; sizes the in-flight counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- acc_len  in  8  results per accumulated group; 0 treated as 1; sampled at group start
- issue  in  1  upstream launched one ALU operation this cycle
- issue_ok  out  1  upstream may assert issue next cycle
- alu_valid  in  1  ALU result valid (single-cycle pulse, no backpressure)
- alu_result  in  2*DATA_WIDTH  {real, imag}, two's complement
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_data  out  2*ACC_WIDTH  {acc_real, acc_imag}
- flush  in  1  synchronous: drop partial group and FIFO contents
- clear_err  in  1  synchronous clear of sticky error flags
- overflow  out  1  sticky: completed group dropped because FIFO full
- underflow  out  1  sticky: alu_valid with zero in-flight count
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

## Operation
- In-flight counter `inflight`: +1 on issue, −1 on alu_valid. Both in the same cycle: no change. alu_valid at inflight==0: counter holds at 0 and underflow is set.
- issue_ok = (occupancy + inflight) < DEPTH. This is conservative: every in-flight result is counted as a potential FIFO entry. issue while issue_ok=0 is still counted; any resulting drop is flagged via overflow.
- Accumulator FSM, states IDLE and ACC:
  - IDLE + alu_valid: latch len = max(acc_len,1), set acc = sign-extended result, cnt=1. If len==1, push and stay IDLE; else go to ACC.
  - ACC + alu_valid: sum = acc + sign-extended result, per component, cnt+1. If cnt+1==len, push sum and go to IDLE; else store sum and stay in ACC.
  - Component arithmetic: signed, saturating to ACC_WIDTH range [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1]. Saturated values keep accumulating from the clamp.
- FIFO: first-word fall-through. out_valid = occupancy≠0, out_data = head. Pop when out_valid & out_ready.
  - Push while full without a pop in the same cycle: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Push and pop on an empty FIFO: the entry is written; the pop is ignored because out_valid=0.
- Pointers wrap modulo DEPTH.
- flush: FSM→IDLE, FIFO emptied, pointers reset, inflight untouched. An alu_valid in the flush cycle is discarded but still decrements inflight.
- clear_err clears overflow/underflow. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - outputs: out_valid=0, out_data=0, occupancy=0, issue_ok=1, overflow=0, underflow=0
  - internal: FSM=IDLE, inflight=0, pointers=0
- Group completion on alu_valid at cycle t: out_valid=1 at t+1 (1-cycle latency), for an empty FIFO.
- issue_ok is registered-path combinational from the counters. It reflects the issue/alu_valid/push/pop of cycle t at t+1.
- acc_len changes mid-group have no effect until the next group start.
- Reset mid-group or mid-drain: all state is discarded immediately (asynchronous).

## Test plan
- acc_len=1, issue 3 ops with results (1,2),(−3,4),(5,−6), out_ready=1 → three outputs in order, each 1 cycle after its alu_valid. issue_ok returns to 1.
- acc_len=4, results (1000,−1000)×4 → single output (4000,−4000) on the cycle after the 4th result. No output before.
- acc_len=2 with ACC_WIDTH=17, results (32767,−32768)×2 → output (65534,−65536). Then (32767,32767)×4 with acc_len=4 → real and imag both clamp at 65535.
- out_ready=0, acc_len=1, issue whenever issue_ok=1 → issue_ok falls after DEPTH issues, occupancy reaches DEPTH, overflow stays 0. Forcing one extra issue+result → overflow=1 and FIFO contents unchanged.
- FIFO full, alu_valid completing a group with out_ready=1 in the same cycle → occupancy stays DEPTH, new entry appears at tail, no overflow.
- acc_len=3, two results, then flush → no output. The next 3 results produce one correct sum. alu_valid with inflight=0 → underflow=1; clear_err → 0.
